// File: rtl/pc_sequencer_if.sv
// Fetch/redirect bus between the next-PC sequencer and its surroundings
// (PC register, instruction memory, pipeline control).
// Optional feature macro: PC_EXC_EN adds the exception request line.
interface pc_sequencer_if;
  logic [31:0] pc_cur;
  logic [31:0] pc_next;
  logic        pc_ena;
  logic        imem_req;
  logic        imem_ack;
  logic        fetch_valid;
  logic        stall;
  logic        br_taken;
  logic [15:0] br_offset;
  logic        jump;
  logic [25:0] jump_index;
  logic        jr;
  logic [31:0] jr_target;
`ifdef PC_EXC_EN
  logic        exc;
`endif

  modport master (
`ifdef PC_EXC_EN
    input  exc,
`endif
    input  pc_cur, imem_ack, stall, br_taken, br_offset,
    input  jump, jump_index, jr, jr_target,
    output pc_next, pc_ena, imem_req, fetch_valid
  );

  modport slave (
`ifdef PC_EXC_EN
    output exc,
`endif
    output pc_cur, imem_ack, stall, br_taken, br_offset,
    output jump, jump_index, jr, jr_target,
    input  pc_next, pc_ena, imem_req, fetch_valid
  );
endinterface

// File: rtl/pc_sequencer.sv
// Next-PC sequencer: picks the next fetch address by fixed priority, runs the
// instruction fetch handshake, holds the PC on stalls and buffers redirects
// that arrive while the PC cannot be loaded.
// Optional feature macro: PC_EXC_EN enables the exception redirect (priority 4).
//
// state | meaning
// BOOT  | first cycle after reset, loads RESET_VECTOR
// FETCH | fetch of pc_cur outstanding, waiting for imem_ack
// HOLD  | fetch done but pipeline stalled, PC held until stall drops
module pc_sequencer (
  input  logic          clk,
  input  logic          rst,
  pc_sequencer_if.master bus
);
  localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;
`ifdef PC_EXC_EN
  localparam logic [31:0] EXC_VECTOR   = 32'h0000_0080;
`endif

  typedef enum logic [1:0] {BOOT, FETCH, HOLD} state_t;

  state_t      state, state_nxt;
  logic        pending_valid, pending_valid_nxt;
  logic [31:0] pending_addr, pending_addr_nxt;
  logic [2:0]  pending_prio, pending_prio_nxt;

  logic [31:0] pc_plus4, br_target, jump_target, jr_addr;
  logic [2:0]  cur_prio;
  logic [31:0] cur_addr;
  logic [31:0] sel_addr;
  logic        capture;

  logic        req_int, fv_int, ena_int, buffer;
  logic [31:0] next_int;

  assign pc_plus4    = bus.pc_cur + 32'd4;
  assign br_target   = pc_plus4 + {{14{bus.br_offset[15]}}, bus.br_offset, 2'b00};
  assign jump_target = {pc_plus4[31:28], bus.jump_index, 2'b00};
  assign jr_addr     = {bus.jr_target[31:2], 2'b00};

  // Highest-priority redirect requested in this cycle (later ifs override).
  always_comb begin
    cur_prio = 3'd0;
    cur_addr = pc_plus4;
    if (bus.br_taken) begin
      cur_prio = 3'd1;
      cur_addr = br_target;
    end
    if (bus.jump) begin
      cur_prio = 3'd2;
      cur_addr = jump_target;
    end
    if (bus.jr) begin
      cur_prio = 3'd3;
      cur_addr = jr_addr;
    end
`ifdef PC_EXC_EN
    if (bus.exc) begin
      cur_prio = 3'd4;
      cur_addr = EXC_VECTOR;
    end
`endif
  end

  // Buffered redirect only wins when strictly higher than the live one.
  assign sel_addr = (pending_valid && (pending_prio > cur_prio)) ? pending_addr : cur_addr;
  assign capture  = (cur_prio != 3'd0) && (!pending_valid || (cur_prio >= pending_prio));

  // State and pending-buffer registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= BOOT;
      pending_valid <= 1'b0;
      pending_addr  <= 32'd0;
      pending_prio  <= 3'd0;
    end else begin
      state         <= state_nxt;
      pending_valid <= pending_valid_nxt;
      pending_addr  <= pending_addr_nxt;
      pending_prio  <= pending_prio_nxt;
    end
  end

  // Next-state, handshake outputs and pending-buffer update.
  always_comb begin
    state_nxt         = state;
    pending_valid_nxt = pending_valid;
    pending_addr_nxt  = pending_addr;
    pending_prio_nxt  = pending_prio;
    req_int           = 1'b0;
    fv_int            = 1'b0;
    ena_int           = 1'b1;
    next_int          = sel_addr;
    buffer            = 1'b0;
    unique case (state)
      BOOT: begin
        next_int  = RESET_VECTOR;
        ena_int   = 1'b0;
        state_nxt = FETCH;
      end
      FETCH: begin
        req_int = 1'b1;
        if (!bus.imem_ack) begin
          buffer = 1'b1;
        end else if (!bus.stall) begin
          fv_int            = 1'b1;
          ena_int           = 1'b0;
          pending_valid_nxt = 1'b0;
          pending_addr_nxt  = 32'd0;
          pending_prio_nxt  = 3'd0;
        end else begin
          // Ack consumed under stall: keep any redirect for the HOLD exit.
          buffer    = 1'b1;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (bus.stall) begin
          buffer = 1'b1;
        end else begin
          ena_int           = 1'b0;
          pending_valid_nxt = 1'b0;
          pending_addr_nxt  = 32'd0;
          pending_prio_nxt  = 3'd0;
          state_nxt         = FETCH;
        end
      end
      default: begin
        state_nxt = BOOT;
      end
    endcase
    if (buffer && capture) begin
      pending_valid_nxt = 1'b1;
      pending_addr_nxt  = cur_addr;
      pending_prio_nxt  = cur_prio;
    end
  end

  // Reset forces outputs idle immediately, independent of the clock.
  assign bus.imem_req    = rst & req_int;
  assign bus.fetch_valid = rst & fv_int;
  assign bus.pc_ena      = ~rst | ena_int;
  assign bus.pc_next     = rst ? next_int : 32'd0;
endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: owns the PC register, drives directed and random
// stimulus and compares against a redirect-history reference model.
`timescale 1ns/1ps
module tb_pc_sequencer;
  localparam logic [31:0] PC_RST = 32'h1234_5670;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pc_sequencer_if bus();
  pc_sequencer dut (.clk(clk), .rst(rst), .bus(bus));

  logic        preset_en  = 1'b0;
  logic [31:0] preset_val = 32'd0;
  logic [31:0] pc_reg;

  // PC register; preset lets the bench jump to a chosen address while holding.
  always @(posedge clk or negedge rst) begin
    if (!rst) pc_reg <= PC_RST;
    else if (preset_en) pc_reg <= preset_val;
    else if (!bus.pc_ena) pc_reg <= bus.pc_next;
  end
  assign bus.pc_cur = pc_reg;

  // Reference model: phase (0 boot, 1 fetch, 2 hold), expected PC and the
  // list of redirects seen since the last load, in arrival order.
  int          mode = 0;
  logic [31:0] mpc  = PC_RST;
  int          q_prio[$];
  logic [31:0] q_addr[$];
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    bus.br_taken   = 1'b0;
    bus.br_offset  = 16'd0;
    bus.jump       = 1'b0;
    bus.jump_index = 26'd0;
    bus.jr         = 1'b0;
    bus.jr_target  = 32'd0;
`ifdef PC_EXC_EN
    bus.exc        = 1'b0;
`endif
  endtask

  // One clock cycle: check outputs, advance the model, check the PC register.
  task automatic tick();
    int          cp[$];
    logic [31:0] ca[$];
    logic [31:0] p4, best;
    int          bp, off;
    logic        load, record, e_req, e_fv;
    #1;
    if (!rst) begin
      chk("rst_req", 32'(bus.imem_req), 32'd0);
      chk("rst_fv", 32'(bus.fetch_valid), 32'd0);
      chk("rst_ena", 32'(bus.pc_ena), 32'd1);
      chk("rst_next", bus.pc_next, 32'd0);
      mode = 0;
      q_prio.delete();
      q_addr.delete();
      mpc = PC_RST;
    end else begin
      p4 = mpc + 32'd4;
      if (bus.br_taken) begin
        off = $signed(bus.br_offset);
        cp.push_back(1);
        ca.push_back(p4 + 32'(off * 4));
      end
      if (bus.jump) begin
        cp.push_back(2);
        ca.push_back((p4 & 32'hF000_0000) | (32'(bus.jump_index) << 2));
      end
      if (bus.jr) begin
        cp.push_back(3);
        ca.push_back(bus.jr_target & ~32'h3);
      end
`ifdef PC_EXC_EN
      if (bus.exc) begin
        cp.push_back(4);
        ca.push_back(32'h0000_0080);
      end
`endif
      // Highest priority wins; among equals the most recent one wins.
      bp = 0;
      best = p4;
      foreach (q_prio[i]) if (q_prio[i] >= bp) begin bp = q_prio[i]; best = q_addr[i]; end
      foreach (cp[i]) if (cp[i] >= bp) begin bp = cp[i]; best = ca[i]; end
      load = 1'b0; record = 1'b0; e_req = 1'b0; e_fv = 1'b0;
      case (mode)
        0: begin load = 1'b1; best = 32'h0000_0000; mode = 1; end
        1: begin
          e_req = 1'b1;
          if (bus.imem_ack && !bus.stall) begin load = 1'b1; e_fv = 1'b1; end
          else begin
            record = 1'b1;
            if (bus.imem_ack) mode = 2;
          end
        end
        default: begin
          if (bus.stall) record = 1'b1;
          else begin load = 1'b1; mode = 1; end
        end
      endcase
      chk("imem_req", 32'(bus.imem_req), 32'(e_req));
      chk("fetch_valid", 32'(bus.fetch_valid), 32'(e_fv));
      chk("pc_ena", 32'(bus.pc_ena), 32'(!load));
      if (load) begin
        chk("pc_next", bus.pc_next, best);
        mpc = best;
        q_prio.delete();
        q_addr.delete();
      end
      if (record) foreach (cp[i]) begin q_prio.push_back(cp[i]); q_addr.push_back(ca[i]); end
    end
    @(posedge clk);
    if (rst && preset_en) mpc = preset_val;
    #1;
    chk("pc_reg", pc_reg, mpc);
    @(negedge clk);
  endtask

  task automatic preset(input logic [31:0] addr);
    clr();
    bus.imem_ack = 1'b0;
    bus.stall    = 1'b0;
    preset_en    = 1'b1;
    preset_val   = addr;
    tick();
    preset_en    = 1'b0;
  endtask

  initial begin
    clr();
    bus.imem_ack = 1'b0;
    bus.stall    = 1'b0;
    @(negedge clk);
    tick();
    tick();

    // Boot and zero-wait sequential fetch.
    rst = 1'b1;
    bus.imem_ack = 1'b1;
    tick();
    chk("boot_pc", pc_reg, 32'h0);
    chk("seq_fv", 32'(bus.fetch_valid), 32'd1);
    tick();
    chk("seq_pc4", pc_reg, 32'h4);
    tick();
    chk("seq_pc8", pc_reg, 32'h8);

    // Backward branch, then jump.
    preset(32'h0000_0100);
    bus.imem_ack = 1'b1;
    bus.br_taken = 1'b1;
    bus.br_offset = 16'hFFFE;
    tick();
    chk("branch_pc", pc_reg, 32'h0000_00FC);
    preset(32'h1000_0000);
    bus.imem_ack = 1'b1;
    bus.jump = 1'b1;
    bus.jump_index = 26'h0000040;
    tick();
    chk("jump_pc", pc_reg, 32'h1000_0100);

    // Jump and branch during a 3-cycle wait: jump wins, pending then cleared.
    clr();
    bus.imem_ack = 1'b0;
    bus.jump = 1'b1;
    bus.jump_index = 26'h0000123;
    bus.br_taken = 1'b1;
    bus.br_offset = 16'h0005;
    repeat (3) tick();
    clr();
    bus.imem_ack = 1'b1;
    tick();
    chk("wait_jump_pc", pc_reg, 32'h1000_048C);
    tick();
    chk("pending_cleared", pc_reg, 32'h1000_0490);

    // Stall hold with a JR pulse mid-stall.
    bus.stall = 1'b1;
    tick();
    tick();
    bus.jr = 1'b1;
    bus.jr_target = 32'h0000_0203;
    tick();
    clr();
    tick();
    tick();
    chk("hold_ena", 32'(bus.pc_ena), 32'd1);
    bus.stall = 1'b0;
    tick();
    chk("hold_jr_pc", pc_reg, 32'h0000_0200);

    // JR (and exception when built in) during a wait.
    bus.imem_ack = 1'b0;
    bus.jr = 1'b1;
    bus.jr_target = 32'h3000_0008;
`ifdef PC_EXC_EN
    bus.exc = 1'b1;
`endif
    tick();
    clr();
    bus.imem_ack = 1'b1;
    tick();
`ifdef PC_EXC_EN
    chk("exc_pc", pc_reg, 32'h0000_0080);
`else
    chk("jr_pc", pc_reg, 32'h3000_0008);
`endif

    // Wrap-around of the sequential address.
    preset(32'hFFFF_FFFC);
    bus.imem_ack = 1'b1;
    tick();
    chk("wrap_pc", pc_reg, 32'h0);

    // Reset during a wait with a pending redirect.
    bus.imem_ack = 1'b0;
    bus.jump = 1'b1;
    bus.jump_index = 26'h0000777;
    tick();
    rst = 1'b0;
    #1;
    chk("async_req_drop", 32'(bus.imem_req), 32'd0);
    tick();
    clr();
    rst = 1'b1;
    bus.imem_ack = 1'b1;
    tick();
    chk("reboot_pc", pc_reg, 32'h0);
    tick();
    chk("no_stale_pc", pc_reg, 32'h4);

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      bus.imem_ack   = ($urandom % 4) != 0;
      bus.stall      = ($urandom % 4) == 0;
      bus.br_taken   = ($urandom % 6) == 0;
      bus.br_offset  = 16'($urandom);
      bus.jump       = ($urandom % 7) == 0;
      bus.jump_index = 26'($urandom);
      bus.jr         = ($urandom % 8) == 0;
      bus.jr_target  = $urandom;
`ifdef PC_EXC_EN
      bus.exc        = ($urandom % 12) == 0;
`endif
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
